// File: rtl/one_bit_full_adder.sv
// Single-bit full adder with a combinational sum/carry path, a one-cycle
// registered copy with valid flag, and an internal carry register for bit-serial use.
module one_bit_full_adder #(
    parameter logic CARRY_INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic Cin,
    input  logic in_valid,
    input  logic serial_en,
    input  logic clr_carry,
    output logic Sum,
    output logic Cout,
    output logic Sum_q,
    output logic Cout_q,
    output logic out_valid,
    output logic carry_state
);

    logic cin_eff;

    always_comb begin
        cin_eff = serial_en ? carry_state : Cin;
        Sum     = A ^ B ^ cin_eff;
        Cout    = (A & B) | (A & cin_eff) | (B & cin_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Sum_q     <= 1'b0;
            Cout_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum_q  <= Sum;
                Cout_q <= Cout;
            end
        end
    end

    // clr_carry outranks a same-cycle serial update; the add itself still used the old carry
    always_ff @(posedge clk) begin
        if (rst || clr_carry) begin
            carry_state <= CARRY_INIT;
        end else if (in_valid && serial_en) begin
            carry_state <= Cout;
        end
    end

endmodule

// File: tb/tb_one_bit_full_adder.sv
// Directed and randomized checks of one_bit_full_adder against an arithmetic
// reference model ({carry,sum} = A + B + carry-in).
module tb_one_bit_full_adder;

    localparam logic CI = 1'b0;

    logic clk = 1'b0;
    logic rst, A, B, Cin, in_valid, serial_en, clr_carry;
    logic Sum, Cout, Sum_q, Cout_q, out_valid, carry_state;

    int n_cmp = 0;
    int n_err = 0;

    logic m_sq = 1'b0, m_cq = 1'b0, m_v = 1'b0, m_c = CI;

    // Expected {Sum,Cout} per {A,B,Cin}, straight from the truth table
    logic [1:0] table_sc [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    one_bit_full_adder #(.CARRY_INIT(CI)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
        .in_valid(in_valid), .serial_en(serial_en), .clr_carry(clr_carry),
        .Sum(Sum), .Cout(Cout), .Sum_q(Sum_q), .Cout_q(Cout_q),
        .out_valid(out_valid), .carry_state(carry_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks combinational outputs, clocks once, advances the model, checks registers
    task automatic cycle();
        logic [1:0] r;
        logic ci;
        #1;
        ci = serial_en ? m_c : Cin;
        r  = 2'(A) + 2'(B) + 2'(ci);
        check("sum", Sum, r[0]);
        check("cout", Cout, r[1]);
        @(posedge clk);
        if (rst) begin
            m_sq = 1'b0; m_cq = 1'b0; m_v = 1'b0; m_c = CI;
        end else begin
            m_v = in_valid;
            if (in_valid) begin
                m_sq = r[0];
                m_cq = r[1];
            end
            if (clr_carry) m_c = CI;
            else if (in_valid && serial_en) m_c = r[1];
        end
        #1;
        check("sum_q", Sum_q, m_sq);
        check("cout_q", Cout_q, m_cq);
        check("out_valid", out_valid, m_v);
        check("carry_state", carry_state, m_c);
    endtask

    task automatic serial_add(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] exp_sum, input logic exp_carry);
        clr_carry = 1'b1; in_valid = 1'b0; serial_en = 1'b1;
        cycle();
        clr_carry = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            A = a[i]; B = b[i]; in_valid = 1'b1; Cin = 1'($urandom_range(0, 1));
            cycle();
            check("serial_sum_bit", Sum_q, exp_sum[i]);
        end
        in_valid = 1'b0;
        check("serial_final_carry", carry_state, exp_carry);
    endtask

    initial begin
        logic s0;
        rst = 1'b1; A = 1'b0; B = 1'b0; Cin = 1'b0;
        in_valid = 1'b0; serial_en = 1'b0; clr_carry = 1'b0;
        @(posedge clk); #1;

        // reset for two cycles
        cycle(); cycle();
        check("rst_sum_q", Sum_q, 1'b0);
        check("rst_cout_q", Cout_q, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_carry", carry_state, CI);
        rst = 1'b0;

        // exhaustive combinational sweep
        for (int unsigned v = 0; v < 8; v++) begin
            logic [2:0] vec;
            vec = 3'(v);
            {A, B, Cin} = vec;
            #1;
            check("tt_sum", Sum, table_sc[v][1]);
            check("tt_cout", Cout, table_sc[v][0]);
            cycle();
        end

        // registered path
        A = 1'b1; B = 1'b1; Cin = 1'b0; in_valid = 1'b1;
        cycle();
        check("reg_sum_q", Sum_q, 1'b0);
        check("reg_cout_q", Cout_q, 1'b1);
        check("reg_valid", out_valid, 1'b1);
        A = 1'b0; B = 1'b0; in_valid = 1'b0;
        cycle();
        check("hold_valid", out_valid, 1'b0);
        check("hold_sum_q", Sum_q, 1'b0);
        check("hold_cout_q", Cout_q, 1'b1);

        serial_add(4'b0111, 4'b0011, 4'b1010, 1'b0);
        serial_add(4'b1111, 4'b0001, 4'b0000, 1'b1);

        // clr_carry priority with carry_state=1
        A = 1'b0; B = 1'b0; clr_carry = 1'b1; in_valid = 1'b1; serial_en = 1'b1;
        #1;
        check("clr_prio_sum", Sum, 1'b1);
        cycle();
        check("clr_prio_carry", carry_state, CI);
        check("clr_prio_sum_q", Sum_q, 1'b1);
        clr_carry = 1'b0;

        // build carry=1, then reset mid-word
        A = 1'b1; B = 1'b1;
        cycle();
        check("mid_carry_set", carry_state, 1'b1);
        rst = 1'b1; A = 1'b0; B = 1'b1;
        cycle();
        check("mid_rst_carry", carry_state, CI);
        check("mid_rst_valid", out_valid, 1'b0);
        rst = 1'b0; in_valid = 1'b0;

        // Cin ignored in serial mode
        A = 1'b1; B = 1'b0; serial_en = 1'b1; Cin = 1'b0;
        #1;
        s0 = Sum;
        check("cin_ign_base", s0, A ^ B ^ m_c);
        Cin = 1'b1;
        #1;
        check("cin_ignored", Sum, s0);
        cycle();

        // randomized run
        for (int unsigned k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 31) == 0);
            clr_carry = ($urandom_range(0, 7) == 0);
            A         = 1'($urandom_range(0, 1));
            B         = 1'($urandom_range(0, 1));
            Cin       = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            serial_en = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/one_bit_full_adder.md
Name: one_bit_full_adder

Overview:
Single-bit binary full adder, the leaf arithmetic cell for ripple-carry and bit-serial adders. It exposes a purely combinational sum/carry path and a one-cycle registered copy with a valid flag. An optional bit-serial mode feeds the carry-in from an internal carry register, so the cell can add multi-bit operands LSB-first, one bit per cycle.

Parameters:
CARRY_INIT, 1'b0, value loaded into the internal carry register on reset and on clr_carry.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
A  input  1  addend bit
B  input  1  addend bit
Cin  input  1  external carry-in; used only when serial_en=0
in_valid  input  1  qualifies A/B/Cin (or A/B in serial mode) for the registered path and the carry update
serial_en  input  1  1 = carry-in taken from the internal carry register instead of Cin
clr_carry  input  1  loads CARRY_INIT into the carry register (start of a new serial word)
Sum  output  1  combinational sum
Cout  output  1  combinational carry-out
Sum_q  output  1  registered Sum
Cout_q  output  1  registered Cout
out_valid  output  1  Sum_q/Cout_q hold a result
carry_state  output  1  current internal carry register value

Behaviour:
- Effective carry-in: cin_eff = serial_en ? carry_state : Cin.
- Sum = A ^ B ^ cin_eff; Cout = (A&B) | (A&cin_eff) | (B&cin_eff). Zero latency; no dependence on clk, rst or in_valid.
- Truth table with serial_en=0 (A B Cin -> Sum Cout): 000->00, 001->10, 010->10, 011->01, 100->10, 101->01, 110->01, 111->11.
- Registered path, on each rising clk edge:
  - rst=1: Sum_q=0, Cout_q=0, out_valid=0, carry_state=CARRY_INIT.
  - Otherwise, if in_valid=1: Sum_q<=Sum, Cout_q<=Cout, out_valid<=1.
  - Otherwise: out_valid<=0 and Sum_q/Cout_q hold their last values.
  - Latency is exactly one cycle from an in_valid input to out_valid.
- Carry register update, when rst=0, in priority order:
  - clr_carry=1: carry_state<=CARRY_INIT, even if in_valid=1 in the same cycle.
  - Else if in_valid=1 and serial_en=1: carry_state<=Cout.
  - Else: hold.
  - When serial_en=0, the carry register is never modified except by reset and clr_carry.
- Simultaneous clr_carry and in_valid with serial_en=1 in the same cycle:
  - The combinational/registered result uses the old carry_state.
  - The register then loads CARRY_INIT.
  - To clear before adding the LSB, assert clr_carry one cycle earlier.
- Reset mid-serial-word: the partial carry is discarded and out_valid drops in the same clock edge.
- serial_en may change on any cycle; it takes effect combinationally.
- No X-propagation masking is required. Outputs are defined whenever all used inputs are 0/1.

Test Plan:
- Exhaustive combinational sweep, serial_en=0, 10 time units per vector, all 8 {A,B,Cin} from 000 to 111 -> Sum/Cout match the truth table, e.g. 011->Sum=0,Cout=1 and 111->Sum=1,Cout=1.
- Registered path: rst for 2 cycles -> Sum_q=0, Cout_q=0, out_valid=0, carry_state=0. Then drive in_valid=1 with A=1,B=1,Cin=0 -> next cycle Sum_q=0, Cout_q=1, out_valid=1. Then in_valid=0 -> out_valid=0 and Sum_q/Cout_q held.
- Serial add 4'b0111+4'b0011 (LSB first), with clr_carry the cycle before and serial_en=1, in_valid=1 for 4 cycles -> Sum_q sequence 0,1,0,1 (LSB first = 1010), final carry_state=0.
- Serial add 4'b1111+4'b0001 -> Sum_q sequence 0,0,0,0 and final carry_state=1, i.e. overflow carry retained.
- clr_carry priority: carry_state=1, assert clr_carry with in_valid=1,serial_en=1,A=B=0 -> Sum=1 that cycle, carry_state=0 next cycle.
- rst asserted mid-serial-word with carry_state=1 -> next edge carry_state=CARRY_INIT, out_valid=0. Cin is ignored while serial_en=1: toggling Cin does not change Sum.
